// File: rtl/bus_pkg.sv
// Shared types and widths for the daisy-chained register bus initiator.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  // A read response as delivered to the host.
  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  err;
  } bus_rsp_t;

  localparam int BUS_RSP_W = $bits(bus_rsp_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } init_state_e;

  // Build a response; error responses never carry data.
  function automatic bus_rsp_t make_rsp(input logic [BUS_ADDR_W-1:0] addr,
                                        input logic [BUS_DATA_W-1:0] rdata,
                                        input logic                  err);
    bus_rsp_t r;
    r.addr  = addr;
    r.rdata = err ? '0 : rdata;
    r.err   = err;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on dout straight
// out of the storage flops, so data pushed at an edge is readable right after it.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Next-state for storage, pointers and occupancy; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Register the FIFO state; storage clears so outputs read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bus_initiator.sv
// Host-side initiator for the register chain: launches host commands at the
// head, matches read returns at the tail against outstanding reads, times out
// lost reads, and meters reads with credits so returns always have space.
import bus_pkg::*;

module bus_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_addr,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic        rw_o,
  output logic        valid_o,
  input  logic [15:0] addr_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [CNT_W-1:0]      credits_q, credits_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  valid_q, valid_d;
  init_state_e           state_q;
  logic                  busy_q;

  logic                  cmd_fire;
  logic                  rd_fire;
  logic                  ret_read;
  logic                  ret_pop;
  logic                  tmo_fire;
  logic                  oq_pop;
  logic                  oq_empty;
  logic [CNT_W-1:0]      oq_count;
  logic [BUS_ADDR_W-1:0] oq_head;
  logic                  rsp_pop;
  logic [CNT_W-1:0]      rsp_count;
  logic [BUS_RSP_W-1:0]  rsp_bits;
  bus_rsp_t              rsp_in;
  bus_rsp_t              rsp_out;

  assign cmd_ready = !rst && (credits_q < CNT_W'(MAX_OUTSTANDING));
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rd_fire   = cmd_fire && !cmd_rw;

  assign ret_read  = valid_i && !rw_i;
  assign oq_empty  = (oq_count == '0);
  assign ret_pop   = ret_read && !oq_empty;
  assign tmo_fire  = !ret_read && !oq_empty && (tmo_q == 16'(TIMEOUT));
  assign oq_pop    = ret_pop || tmo_fire;

  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;

  sync_fifo #(
    .WIDTH (BUS_ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_oq (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_fire),
    .din   (cmd_addr),
    .pop   (oq_pop),
    .dout  (oq_head),
    .count (oq_count)
  );

  // Form the response for a popped read: matched return, mismatch, or timeout.
  always_comb begin
    rsp_in = make_rsp(oq_head, '0, 1'b1);
    if (ret_pop) begin
      rsp_in = make_rsp(addr_i, rdata_i, addr_i != oq_head);
    end
  end

  sync_fifo #(
    .WIDTH (BUS_RSP_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rspq (
    .clk   (clk),
    .rst   (rst),
    .push  (oq_pop),
    .din   (rsp_in),
    .pop   (rsp_pop),
    .dout  (rsp_bits),
    .count (rsp_count)
  );

  assign rsp_out   = bus_rsp_t'(rsp_bits);
  assign rsp_addr  = rsp_out.addr;
  assign rsp_rdata = rsp_out.rdata;
  assign rsp_err   = rsp_out.err;

  // Next values for credits, the loss timer and the head-of-chain launch registers.
  always_comb begin
    credits_d = credits_q;
    case ({rd_fire, rsp_pop})
      2'b10:   credits_d = credits_q + CNT_W'(1);
      2'b01:   credits_d = credits_q - CNT_W'(1);
      default: credits_d = credits_q;
    endcase

    tmo_d = tmo_q + 16'd1;
    if (oq_empty || ret_read || tmo_fire) begin
      tmo_d = '0;
    end

    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    valid_d = cmd_fire;
    if (cmd_fire) begin
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
      rw_d    = cmd_rw;
    end
  end

  // Register credits, timer and launch outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      credits_q <= credits_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      valid_q   <= valid_d;
    end
  end

  // Track whether reads are in flight; busy is the registered WAIT indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_fire) begin
            state_q <= ST_WAIT;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (oq_pop && (oq_count == CNT_W'(1)) && !rd_fire) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a short loss timeout.
module tb_bus_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_addr;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic        rw_o;
  logic        valid_o;
  logic [15:0] addr_i;
  logic [15:0] rdata_i;
  logic        rw_i;
  logic        valid_i;
  logic        busy;

  int total = 0;
  int bad   = 0;

  bus_initiator #(
    .MAX_OUTSTANDING (4),
    .TIMEOUT         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .rw_o      (rw_o),
    .valid_o   (valid_o),
    .addr_i    (addr_i),
    .rdata_i   (rdata_i),
    .rw_i      (rw_i),
    .valid_i   (valid_i),
    .busy      (busy)
  );

  // Free-running clock, rising edge active.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rw,
                               input logic [15:0] a, input logic [15:0] w);
    cmd_valid = v;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = w;
  endtask

  task automatic chainReturn(input logic v, input logic rw,
                             input logic [15:0] a, input logic [15:0] d);
    valid_i = v;
    rw_i    = rw;
    addr_i  = a;
    rdata_i = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic [15:0] a,
                          input logic [15:0] d, input logic e);
    checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
    checkOutput({tag, ".rsp_addr"},  32'(rsp_addr),  32'(a));
    checkOutput({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(d));
    checkOutput({tag, ".rsp_err"},   32'(rsp_err),   32'(e));
  endtask

  // Linear directed sequence covering each operating scenario in turn.
  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    chainReturn(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    checkRsp("rst", 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("rst.addr_o",  32'(addr_o),  32'h0);
    checkOutput("rst.wdata_o", 32'(wdata_o), 32'h0);
    checkOutput("rst.rw_o",    32'(rw_o),    32'd0);
    checkOutput("rst.valid_o", 32'(valid_o), 32'd0);
    checkOutput("rst.busy",    32'(busy),    32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst.ready_after", 32'(cmd_ready), 32'd1);

    $display("[TB] write launch");
    applyStimulus(1'b1, 1'b1, 16'h0003, 16'hBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("wr.valid_o", 32'(valid_o), 32'd1);
    checkOutput("wr.addr_o",  32'(addr_o),  32'h0003);
    checkOutput("wr.wdata_o", 32'(wdata_o), 32'hBEEF);
    checkOutput("wr.rw_o",    32'(rw_o),    32'd1);
    checkOutput("wr.busy",    32'(busy),    32'd0);
    tick();
    checkOutput("wr.valid_o_drop", 32'(valid_o),   32'd0);
    checkOutput("wr.addr_o_hold",  32'(addr_o),    32'h0003);
    checkOutput("wr.no_rsp",       32'(rsp_valid), 32'd0);
    checkOutput("wr.busy_after",   32'(busy),      32'd0);

    $display("[TB] read round-trip");
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("rd.valid_o", 32'(valid_o), 32'd1);
    checkOutput("rd.rw_o",    32'(rw_o),    32'd0);
    checkOutput("rd.addr_o",  32'(addr_o),  32'h0001);
    checkOutput("rd.busy",    32'(busy),    32'd1);
    tick();
    tick();
    chainReturn(1'b1, 1'b0, 16'h0001, 16'h1234);
    tick();
    chainReturn(1'b0, 1'b0, 16'h0, 16'h0);
    checkRsp("rd", 1'b1, 16'h0001, 16'h1234, 1'b0);
    checkOutput("rd.busy_after", 32'(busy),      32'd0);
    checkOutput("rd.cmd_ready",  32'(cmd_ready), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rd.popped", 32'(rsp_valid), 32'd0);

    $display("[TB] credit exhaustion");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("cr.cmd_ready_0", 32'(cmd_ready), 32'd0);
    checkOutput("cr.addr_o",      32'(addr_o),    32'h0013);
    checkOutput("cr.busy",        32'(busy),      32'd1);
    for (int i = 0; i < 4; i++) begin
      chainReturn(1'b1, 1'b0, 16'(16'h0010 + i), 16'(16'h00A0 + i));
      tick();
    end
    chainReturn(1'b0, 1'b0, 16'h0, 16'h0);
    checkRsp("cr.head", 1'b1, 16'h0010, 16'h00A0, 1'b0);
    checkOutput("cr.cmd_ready_full", 32'(cmd_ready), 32'd0);
    checkOutput("cr.busy_drained",   32'(busy),      32'd0);
    tick();
    checkOutput("cr.hold_addr",  32'(rsp_addr),  32'h0010);
    checkOutput("cr.hold_rdata", 32'(rsp_rdata), 32'h00A0);
    checkOutput("cr.hold_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("cr.cmd_ready_back", 32'(cmd_ready), 32'd1);
    checkRsp("cr.second", 1'b1, 16'h0011, 16'h00A1, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checkOutput("cr.drain_addr",  32'(rsp_addr),  32'(16'h0010 + i));
      checkOutput("cr.drain_rdata", 32'(rsp_rdata), 32'(16'h00A0 + i));
      tick();
    end
    rsp_ready = 1'b0;
    checkOutput("cr.empty", 32'(rsp_valid), 32'd0);

    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("to.valid_o", 32'(valid_o), 32'd1);
    checkOutput("to.busy",    32'(busy),    32'd1);
    repeat (8) tick();
    checkOutput("to.not_yet",   32'(rsp_valid), 32'd0);
    checkOutput("to.busy_still", 32'(busy),     32'd1);
    tick();
    checkRsp("to", 1'b1, 16'h0002, 16'h0000, 1'b1);
    checkOutput("to.busy_drop", 32'(busy), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("[TB] address mismatch");
    applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    chainReturn(1'b1, 1'b0, 16'h0006, 16'h5555);
    tick();
    chainReturn(1'b0, 1'b0, 16'h0, 16'h0);
    checkRsp("mm", 1'b1, 16'h0006, 16'h0000, 1'b1);
    checkOutput("mm.busy", 32'(busy), 32'd0);
    chainReturn(1'b1, 1'b0, 16'h0005, 16'h9999);
    tick();
    chainReturn(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("mm.stray_addr", 32'(rsp_addr), 32'h0006);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("mm.stray_dropped", 32'(rsp_valid), 32'd0);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 1'b0, 16'h0007, 16'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("mr.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mr.cmd_ready_rst", 32'(cmd_ready), 32'd0);
    checkOutput("mr.busy_rst",      32'(busy),      32'd0);
    checkOutput("mr.valid_o_rst",   32'(valid_o),   32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("mr.cmd_ready_after", 32'(cmd_ready), 32'd1);
    chainReturn(1'b1, 1'b0, 16'h0007, 16'h0077);
    tick();
    chainReturn(1'b1, 1'b0, 16'h0008, 16'h0088);
    tick();
    chainReturn(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("mr.no_rsp",  32'(rsp_valid), 32'd0);
    checkOutput("mr.busy",    32'(busy),      32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(16'h0020 + i), 16'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("mr.credits_cleared", 32'(cmd_ready), 32'd1);
    checkOutput("mr.busy_new",        32'(busy),      32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
